// File: rtl/majority16_rep_tx_if.sv
// Link bundle for the majority16 repetition transmitter: upstream frame handshake,
// serial chip stream and frame status.
interface majority16_rep_tx_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic [15:0]      in_mask;
    logic             tx_chip;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_sof;
    logic             tx_eof;
    logic [15:0]      word_out;
    logic             word_valid;
    logic             decodable;
    logic [CNT_W-1:0] frame_count;

    // Transmitter side.
    modport slave (
        input  in_valid, in_bit, in_mask, tx_ready,
        output in_ready, tx_chip, tx_valid, tx_sof, tx_eof,
        output word_out, word_valid, decodable, frame_count
    );

    // Environment side: frame source and chip sink.
    modport master (
        output in_valid, in_bit, in_mask, tx_ready,
        input  in_ready, tx_chip, tx_valid, tx_sof, tx_eof,
        input  word_out, word_valid, decodable, frame_count
    );
endinterface

// File: rtl/majority16_rep_tx.sv
// Transmit end of the 16-chip repetition link: encodes one bit per frame, applies an
// error-injection mask, serialises LSB-first and reports majority16 decodability.
module majority16_rep_tx #(
    parameter int unsigned IDLE_GAP = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    majority16_rep_tx_if.slave   link
);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    localparam logic [3:0] GapLast = 4'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

    state_e           state_q, state_d;
    logic [15:0]      code_q, code_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       gap_q, gap_d;
    logic             dec_q, dec_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]       mask_ones;
    logic             send;
    logic             last_xfer;

    always_comb begin
        mask_ones = '0;
        for (int i = 0; i < 16; i++) begin
            mask_ones = mask_ones + 5'(link.in_mask[i]);
        end
    end

    assign send      = (state_q == StSend);
    assign last_xfer = send && link.tx_ready && (idx_q == 4'd15);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (link.in_valid && rdy_q) begin
                    code_d  = {16{link.in_bit}} ^ link.in_mask;
                    idx_d   = '0;
                    // A 1 survives while fewer than 8 chips flip; a 0 also survives the 8/8 tie.
                    dec_d   = link.in_bit ? (mask_ones <= 5'd7) : (mask_ones <= 5'd8);
                    state_d = StSend;
                end
            end
            StSend: begin
                if (link.tx_ready) begin
                    if (idx_q == 4'd15) begin
                        idx_d   = '0;
                        gap_d   = '0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = (IDLE_GAP > 0) ? StGap : StIdle;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered so in_ready stays low through reset and rises on the first clock after.
        rdy_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            code_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            dec_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            dec_q   <= dec_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign link.in_ready    = rdy_q;
    assign link.tx_valid    = send;
    assign link.tx_chip     = send & code_q[idx_q];
    assign link.tx_sof      = send && (idx_q == 4'd0);
    assign link.tx_eof      = send && (idx_q == 4'd15);
    assign link.word_out    = code_q;
    assign link.word_valid  = last_xfer;
    assign link.decodable   = dec_q;
    assign link.frame_count = cnt_q;

endmodule

// File: tb/tb_majority16_rep_tx.sv
// Bench for majority16_rep_tx: vector table, backpressure, mid-frame reset,
// back-to-back throughput with counter wrap, and randomised frames.
module tb_majority16_rep_tx;

    localparam int unsigned CntW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    majority16_rep_tx_if #(.CNT_W(CntW)) link ();

    majority16_rep_tx #(
        .IDLE_GAP(1),
        .CNT_W   (CntW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .link (link)
    );

    typedef struct {
        logic        b;
        logic [15:0] mask;
        logic [15:0] word;
        logic        dec;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    logic [CntW-1:0] exp_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each chip carries the bit unless its mask bit flips it; the receiver
    // outputs 1 when more than half of the 16 chips are 1.
    function automatic logic [15:0] ref_word(input logic b, input logic [15:0] m);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = m[i] ? ~b : b;
        return w;
    endfunction

    function automatic logic ref_dec(input logic b, input logic [15:0] m);
        logic [15:0] w;
        int ones;
        w = ref_word(b, m);
        ones = 0;
        for (int i = 0; i < 16; i++) ones += int'(w[i]);
        return ((ones > 8) ? 1'b1 : 1'b0) == b;
    endfunction

    task automatic do_frame(input string tag, input logic b, input logic [15:0] m,
                            input logic [15:0] exp_word, input logic exp_dec,
                            input logic [31:0] stall_map, input int stall_pct,
                            output int n_cyc);
        int idx;
        int wait_c;
        n_cyc = 0;
        link.in_valid = 1'b1;
        link.in_bit   = b;
        link.in_mask  = m;
        link.tx_ready = 1'b1;
        wait_c = 0;
        @(negedge clk);
        while (link.in_ready !== 1'b1 && wait_c < 100) begin
            check({tag, " idle_txv"}, link.tx_valid, 0);
            @(negedge clk);
            wait_c++;
        end
        check({tag, " accept"}, link.in_ready, 1);
        if (link.in_ready !== 1'b1) begin
            link.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        link.in_valid = 1'b0;
        link.in_bit   = 1'($urandom);
        link.in_mask  = 16'($urandom);
        idx = 0;
        while (idx < 16 && n_cyc < 400) begin
            link.tx_ready = ((n_cyc < 32) ? ~stall_map[n_cyc] : 1'b1) &&
                            ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            check({tag, " tx_valid"}, link.tx_valid, 1);
            check({tag, " tx_chip"}, link.tx_chip, exp_word[idx]);
            check({tag, " tx_sof"}, link.tx_sof, (idx == 0));
            check({tag, " tx_eof"}, link.tx_eof, (idx == 15));
            check({tag, " in_ready_send"}, link.in_ready, 0);
            check({tag, " word_valid"}, link.word_valid, (idx == 15) && link.tx_ready);
            if (link.word_valid === 1'b1) begin
                check({tag, " word_out"}, link.word_out, exp_word);
                check({tag, " decodable"}, link.decodable, exp_dec);
                check({tag, " count_pre"}, link.frame_count, exp_count);
            end
            if (link.tx_ready) idx++;
            @(posedge clk); #1;
            n_cyc++;
        end
        check({tag, " chips_done"}, idx, 16);
        if (idx == 16) exp_count++;
        link.tx_ready = 1'b1;
        #1;
        check({tag, " count_post"}, link.frame_count, exp_count);
        check({tag, " gap_txv"}, link.tx_valid, 0);
        check({tag, " gap_ready"}, link.in_ready, 0);
        check({tag, " word_hold"}, link.word_out, exp_word);
        check({tag, " dec_hold"}, link.decodable, exp_dec);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int nc;
        int wait_c;
        logic [15:0] exp_q[$];
        logic [15:0] w;
        logic b;
        logic [15:0] m;
        int accepts, done, cyc, last_acc, viol;
        bit seen_wrap;
        logic acc_now;

        vecs[0] = '{1'b1, 16'h0000, 16'hFFFF, 1'b1};
        vecs[1] = '{1'b1, 16'h6E82, 16'h917D, 1'b1};
        vecs[2] = '{1'b0, 16'h5555, 16'h5555, 1'b1};
        vecs[3] = '{1'b1, 16'hAAAA, 16'h5555, 1'b0};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0};
        vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[6] = '{1'b0, 16'h00FF, 16'h00FF, 1'b1};
        vecs[7] = '{1'b1, 16'h00FF, 16'hFF00, 1'b0};
        vecs[8] = '{1'b1, 16'h007F, 16'hFF80, 1'b1};

        link.in_valid = 1'b0;
        link.in_bit   = 1'b0;
        link.in_mask  = '0;
        link.tx_ready = 1'b0;

        // Reset state
        #2;
        check("rst in_ready", link.in_ready, 0);
        check("rst tx_valid", link.tx_valid, 0);
        check("rst word_out", link.word_out, 0);
        check("rst decodable", link.decodable, 0);
        check("rst word_valid", link.word_valid, 0);
        check("rst frame_count", link.frame_count, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst ready_before_clk", link.in_ready, 0);
        @(posedge clk); #1;
        check("rst ready_after_clk", link.in_ready, 1);

        // Vector table, no backpressure: 16 chip cycles per frame
        for (int i = 0; i < 9; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].b, vecs[i].mask, vecs[i].word,
                     vecs[i].dec, 32'h0, 0, nc);
            check($sformatf("vec%0d cycles", i), nc, 16);
        end

        // Backpressure on frame cycles 3-6
        do_frame("bp", 1'b0, 16'hF830, 16'hF830, 1'b1, 32'h0000_003C, 0, nc);
        check("bp cycles", nc, 20);

        // Reset at chip 7
        link.in_valid = 1'b1;
        link.in_bit   = 1'b0;
        link.in_mask  = 16'h1234;
        link.tx_ready = 1'b1;
        wait_c = 0;
        @(negedge clk);
        while (link.in_ready !== 1'b1 && wait_c < 100) begin
            @(negedge clk);
            wait_c++;
        end
        check("mid accept", link.in_ready, 1);
        @(posedge clk); #1;
        link.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid pre_txv", link.tx_valid, 1);
        check("mid pre_sof", link.tx_sof, 0);
        rst_n = 1'b0;
        #1;
        check("mid txv", link.tx_valid, 0);
        check("mid word_valid", link.word_valid, 0);
        check("mid frame_count", link.frame_count, 0);
        check("mid word_out", link.word_out, 0);
        exp_count = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_frame("post_rst", 1'b1, 16'h0000, 16'hFFFF, 1'b1, 32'h0, 0, nc);
        check("post_rst cycles", nc, 16);

        // 256 back-to-back frames with in_valid held high
        accepts = 0; done = 0; cyc = 0; last_acc = -1; viol = 0; seen_wrap = 0;
        link.tx_ready = 1'b1;
        b = 1'($urandom);
        m = 16'($urandom);
        link.in_bit   = b;
        link.in_mask  = m;
        link.in_valid = 1'b1;
        while (done < 256 && cyc < 256 * 18 + 100) begin
            acc_now = 1'b0;
            @(negedge clk);
            if (link.in_ready === 1'b1 && link.tx_valid === 1'b1) viol++;
            if (link.in_valid && link.in_ready === 1'b1) begin
                if (last_acc >= 0) check("tput period", cyc - last_acc, 18);
                last_acc = cyc;
                exp_q.push_back(ref_word(b, m));
                accepts++;
                acc_now = 1'b1;
            end
            if (link.word_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("tput spurious_word", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("tput word_out", link.word_out, w);
                end
                check("tput count", link.frame_count, exp_count);
                if (exp_count == 8'd255) seen_wrap = 1'b1;
                exp_count++;
                done++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                // Gap before the next accept exercises the "held" state with in_ready low.
                if (link.in_ready === 1'b1) viol++;
                b = 1'($urandom);
                m = 16'($urandom);
                link.in_bit  = b;
                link.in_mask = m;
                if (accepts == 256) link.in_valid = 1'b0;
            end
            cyc++;
        end
        link.in_valid = 1'b0;
        check("tput frames", done, 256);
        check("tput ready_busy", viol, 0);
        check("tput wrap_seen", seen_wrap, 1);
        #1;
        check("tput final_count", link.frame_count, exp_count);

        // Randomised frames with random backpressure
        for (int i = 0; i < 20; i++) begin
            b = 1'($urandom);
            m = 16'($urandom);
            if (i % 4 == 0) m = 16'hFFFF >> $urandom_range(15, 0);
            do_frame($sformatf("rnd%0d", i), b, m, ref_word(b, m), ref_dec(b, m),
                     32'h0, 30, nc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
